// File: rtl/sb_tx_arbiter.sv
// Arbitrates the shared sideband TX serializer between the tx point-test requester
// and the rx point-test responder; holds the winner's message for the whole send.
module sb_tx_arbiter #(
    parameter int MSG_W      = 4,
    parameter int DATA_W     = 16,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MSG_W-1:0]  i_tx_msg,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    input  logic              i_tx_data_valid,
    input  logic [MSG_W-1:0]  i_rx_msg,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_rx_data_valid,
    input  logic              i_sb_busy,
    output logic [MSG_W-1:0]  o_sb_msg,
    output logic [DATA_W-1:0] o_sb_data,
    output logic              o_sb_valid,
    output logic              o_sb_data_valid,
    output logic              o_busy_negedge,
    output logic              o_rx_owner,
    output logic              o_tx_done,
    output logic              o_rx_done,
    output logic              o_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, SENDING, GAP} state_t;

    state_t            state_q, state_d;
    logic [MSG_W-1:0]  msg_q, msg_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              dv_q, dv_d;
    logic              sb_valid_q, sb_valid_d;
    logic              negedge_q, negedge_d;
    logic              rx_owner_q, rx_owner_d;
    logic              tx_done_q, tx_done_d;
    logic              rx_done_q, rx_done_d;
    logic              timeout_q, timeout_d;
    logic              busy_dly_q, busy_dly_d;
    logic              last_rx_q, last_rx_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic [TW-1:0]     to_cnt_q, to_cnt_d;
    logic              grant_rx;

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        data_d     = data_q;
        dv_d       = dv_q;
        rx_owner_d = rx_owner_q;
        last_rx_d  = last_rx_q;
        sb_valid_d = 1'b0;
        negedge_d  = 1'b0;
        tx_done_d  = 1'b0;
        rx_done_d  = 1'b0;
        timeout_d  = 1'b0;
        busy_dly_d = i_sb_busy;
        gap_cnt_d  = '0;
        to_cnt_d   = to_cnt_q;
        // On a tie the requester that did not win last time takes the grant.
        grant_rx   = i_rx_valid && (!i_tx_valid || !last_rx_q);

        case (state_q)
            IDLE: begin
                if (i_tx_valid || i_rx_valid) begin
                    state_d    = LAUNCH;
                    sb_valid_d = 1'b1;
                    rx_owner_d = grant_rx;
                    last_rx_d  = grant_rx;
                    msg_d      = grant_rx ? i_rx_msg : i_tx_msg;
                    data_d     = grant_rx ? i_rx_data : i_tx_data;
                    dv_d       = grant_rx ? i_rx_data_valid : i_tx_data_valid;
                end
            end
            LAUNCH: begin
                state_d  = WAIT_BUSY;
                to_cnt_d = '0;
            end
            WAIT_BUSY: begin
                if (i_sb_busy) begin
                    state_d = SENDING;
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d   = GAP;
                    timeout_d = 1'b1;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            SENDING: begin
                if (busy_dly_q && !i_sb_busy) begin
                    state_d   = GAP;
                    negedge_d = 1'b1;
                    tx_done_d = !rx_owner_q;
                    rx_done_d = rx_owner_q;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            msg_q      <= '0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            sb_valid_q <= 1'b0;
            negedge_q  <= 1'b0;
            rx_owner_q <= 1'b0;
            tx_done_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            timeout_q  <= 1'b0;
            busy_dly_q <= 1'b0;
            last_rx_q  <= 1'b0;
            gap_cnt_q  <= '0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            sb_valid_q <= sb_valid_d;
            negedge_q  <= negedge_d;
            rx_owner_q <= rx_owner_d;
            tx_done_q  <= tx_done_d;
            rx_done_q  <= rx_done_d;
            timeout_q  <= timeout_d;
            busy_dly_q <= busy_dly_d;
            last_rx_q  <= last_rx_d;
            gap_cnt_q  <= gap_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign o_sb_msg        = msg_q;
    assign o_sb_data       = data_q;
    assign o_sb_valid      = sb_valid_q;
    assign o_sb_data_valid = dv_q;
    assign o_busy_negedge  = negedge_q;
    assign o_rx_owner      = rx_owner_q;
    assign o_tx_done       = tx_done_q;
    assign o_rx_done       = rx_done_q;
    assign o_timeout       = timeout_q;

endmodule

// File: tb/tb_sb_tx_arbiter.sv
// Randomized scoreboard bench for sb_tx_arbiter: the driver predicts each grant and
// completion event from the arbitration rules, the monitor matches DUT pulses to them.
module tb_sb_tx_arbiter;

    localparam int GAP = 2;
    localparam int TO  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_tx_msg, i_rx_msg;
    logic [15:0] i_tx_data, i_rx_data;
    logic        i_tx_valid, i_tx_data_valid, i_rx_valid, i_rx_data_valid;
    logic        i_sb_busy;
    logic [3:0]  o_sb_msg;
    logic [15:0] o_sb_data;
    logic        o_sb_valid, o_sb_data_valid, o_busy_negedge, o_rx_owner;
    logic        o_tx_done, o_rx_done, o_timeout;

    sb_tx_arbiter #(.MSG_W(4), .DATA_W(16), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_tx_msg(i_tx_msg), .i_tx_data(i_tx_data),
        .i_tx_valid(i_tx_valid), .i_tx_data_valid(i_tx_data_valid),
        .i_rx_msg(i_rx_msg), .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid), .i_rx_data_valid(i_rx_data_valid),
        .i_sb_busy(i_sb_busy),
        .o_sb_msg(o_sb_msg), .o_sb_data(o_sb_data),
        .o_sb_valid(o_sb_valid), .o_sb_data_valid(o_sb_data_valid),
        .o_busy_negedge(o_busy_negedge), .o_rx_owner(o_rx_owner),
        .o_tx_done(o_tx_done), .o_rx_done(o_rx_done), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = launch, 1 = completion, 2 = timeout
    typedef struct {
        int          kind;
        int          at;
        bit          rx;
        logic [3:0]  msg;
        logic [15:0] data;
        bit          dv;
    } ev_t;
    ev_t expq[$];

    int n_tests = 0;
    int n_fail  = 0;

    bit          pend [2];
    logic [3:0]  pmsg [2];
    logic [15:0] pdata[2];
    bit          pdv  [2];
    bit          last_rx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input int r, input bit v, input logic [3:0] m,
                         input logic [15:0] d, input bit dv);
        if (r == 0) begin
            i_tx_valid = v; i_tx_msg = m; i_tx_data = d; i_tx_data_valid = dv;
        end else begin
            i_rx_valid = v; i_rx_msg = m; i_rx_data = d; i_rx_data_valid = dv;
        end
    endtask

    task automatic new_req(input int r);
        pend[r]  = 1'b1;
        pmsg[r]  = 4'($urandom);
        pdata[r] = 16'($urandom);
        pdv[r]   = 1'($urandom);
        apply(r, 1'b1, pmsg[r], pdata[r], pdv[r]);
    endtask

    // Called in a cycle where the arbiter is idle and at least one request is up.
    task automatic run_txn(input bit force_to);
        int  now, w, b, len, ev_c, idle_c, drop_c;
        bit  to, busy_in_launch;
        ev_t e;
        now = cyc;
        if (pend[0] && pend[1]) w = last_rx ? 0 : 1;
        else                    w = pend[1] ? 1 : 0;
        last_rx = (w == 1);
        e = '{0, now + 1, bit'(w), pmsg[w], pdata[w], pdv[w]};
        expq.push_back(e);
        to = force_to || ($urandom_range(0, 5) == 0);
        busy_in_launch = 1'($urandom);
        b   = 0;
        len = 0;
        if (to) begin
            ev_c = now + 2 + TO;
            e = '{2, ev_c, bit'(w), pmsg[w], pdata[w], pdv[w]};
        end else begin
            b    = now + 2 + int'($urandom_range(0, TO - 1));
            len  = int'($urandom_range(1, 6));
            ev_c = b + len + 1;
            e = '{1, ev_c, bit'(w), pmsg[w], pdata[w], pdv[w]};
        end
        expq.push_back(e);
        idle_c = ev_c + GAP;
        // Owner may drop early (no abort) or hold past its completion (stale valid).
        if ($urandom_range(0, 1) == 1) drop_c = ev_c;
        else drop_c = now + 1 + int'($urandom_range(0, ev_c - now - 1));
        pend[w] = 1'b0;
        for (int c = now + 1; c < idle_c; c++) begin
            tick();
            if (to) i_sb_busy = busy_in_launch && (c == now + 1);
            else    i_sb_busy = (c >= b) && (c < b + len);
            apply(w, c <= drop_c, 4'($urandom), 16'($urandom), 1'($urandom));
            if (!pend[1 - w] && $urandom_range(0, 7) == 0) new_req(1 - w);
        end
        tick();
        i_sb_busy = 1'b0;
        apply(w, 1'b0, 4'($urandom), 16'($urandom), 1'b0);
    endtask

    logic [3:0]  lat_msg;
    logic [15:0] lat_data;
    bit          lat_dv, lat_rx;

    always @(negedge clk) begin
        logic [4:0] act;
        logic [4:0] expv;
        ev_t        e;
        if (rst) begin
            lat_msg = '0; lat_data = '0; lat_dv = 1'b0; lat_rx = 1'b0;
        end else begin
            while (expq.size() > 0 && expq[0].at < cyc) begin
                e = expq.pop_front();
                chk("missed_event_cycle", 64'(cyc), 64'(e.at));
            end
            act = {o_sb_valid, o_busy_negedge, o_tx_done, o_rx_done, o_timeout};
            if (act != 5'b0) begin
                if (expq.size() == 0) begin
                    chk("unexpected_pulse", 64'(act), 64'(0));
                end else begin
                    e = expq.pop_front();
                    case (e.kind)
                        0:       expv = 5'b10000;
                        1:       expv = {1'b0, 1'b1, !e.rx, e.rx, 1'b0};
                        default: expv = 5'b00001;
                    endcase
                    chk("pulse_kind", 64'(act), 64'(expv));
                    chk("pulse_cycle", 64'(cyc), 64'(e.at));
                    if (e.kind == 0) begin
                        lat_msg = e.msg; lat_data = e.data; lat_dv = e.dv; lat_rx = e.rx;
                    end
                end
            end
            chk("latched_fields", {o_rx_owner, o_sb_data_valid, o_sb_msg, o_sb_data},
                {lat_rx, lat_dv, lat_msg, lat_data});
        end
    end

    initial begin
        int  now, guard;
        ev_t e;
        rst = 1'b1;
        i_sb_busy = 1'b0;
        apply(0, 1'b0, '0, '0, 1'b0);
        apply(1, 1'b0, '0, '0, 1'b0);
        pend[0] = 1'b0; pend[1] = 1'b0;
        last_rx = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {o_sb_msg, o_sb_data, o_sb_valid, o_sb_data_valid, o_busy_negedge,
            o_rx_owner, o_tx_done, o_rx_done, o_timeout}, 64'(0));
        rst = 1'b0;
        new_req(0);
        new_req(1);

        for (int k = 0; k < 60; k++) begin
            if (!pend[0] && !pend[1]) begin
                repeat ($urandom_range(0, 3)) tick();
                case ($urandom_range(0, 2))
                    0:       new_req(0);
                    1:       new_req(1);
                    default: begin new_req(0); new_req(1); end
                endcase
            end
            run_txn(k == 5);
            if (!pend[0] && $urandom_range(0, 2) == 0) new_req(0);
            if (!pend[1] && $urandom_range(0, 2) == 0) new_req(1);
        end

        apply(0, 1'b0, '0, '0, 1'b0);
        apply(1, 1'b0, '0, '0, 1'b0);
        pend[0] = 1'b0; pend[1] = 1'b0;
        repeat (2) tick();

        // Reset while a tx message is on the wire.
        now = cyc;
        new_req(0);
        e = '{0, now + 1, 1'b0, pmsg[0], pdata[0], pdv[0]};
        expq.push_back(e);
        pend[0] = 1'b0;
        tick();
        apply(0, 1'b0, 4'($urandom), 16'($urandom), 1'b0);
        tick();
        i_sb_busy = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_sb_busy = 1'b0;
        last_rx = 1'b0;
        chk("mid_send_reset_outputs", {o_sb_msg, o_sb_data, o_sb_valid, o_sb_data_valid,
            o_busy_negedge, o_rx_owner, o_tx_done, o_rx_done, o_timeout}, 64'(0));
        repeat (4) begin
            tick();
            chk("post_reset_no_pulse", {o_sb_valid, o_busy_negedge, o_tx_done, o_rx_done,
                o_timeout}, 64'(0));
        end

        new_req(0);
        new_req(1);
        run_txn(1'b0);
        if (!pend[0] && !pend[1]) new_req(0);
        run_txn(1'b0);
        apply(0, 1'b0, '0, '0, 1'b0);
        apply(1, 1'b0, '0, '0, 1'b0);

        guard = 0;
        while (expq.size() > 0 && guard < 100) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        chk("queue_drained", 64'(expq.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
